// File: rtl/depacketizer_fsm.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM and RX FIFO write with error pulses.
// Define RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module depacketizer_fsm #(
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_write_en,
    output logic                  rx_busy,
    output logic                  frame_error,
    output logic                  overrun,
    output logic                  parity_error,
    output logic [2:0]            debug_state
);
    localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam int CNT_W      = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
    localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BAUD_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        WRITE    = 3'd4,
        ERR_WAIT = 3'd5,
        PARITY   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rx_meta_q, rx_s_q;
`ifdef RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            wdata_q   <= '0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
`ifdef RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            wdata_q   <= wdata_d;
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
`ifdef RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        idx_d         = idx_q;
        shift_d       = shift_q;
        wdata_d       = wdata_q;
        fifo_write_en = 1'b0;
        frame_error   = 1'b0;
        overrun       = 1'b0;
        parity_error  = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_d     = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == IDX_LAST) begin
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rx_s_q;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = WRITE;
                    end else begin
                        frame_error = 1'b1;
                        state_d     = ERR_WAIT;
                    end
                end
            end
            WRITE: begin
                cnt_d   = '0;
                state_d = IDLE;
`ifdef RX_PARITY_EN
                if (par_bad_q) begin
                    parity_error = 1'b1;
                end else
`endif
                if (fifo_full) begin
                    overrun = 1'b1;
                end else begin
                    fifo_write_en = 1'b1;
                    wdata_d       = shift_q;
                end
            end
            ERR_WAIT: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Byte is presented straight from the shift register during the strobe, then held.
    assign fifo_wdata  = fifo_write_en ? shift_q : wdata_q;
    assign rx_busy     = (state_q != IDLE);
    assign debug_state = state_q;

endmodule

// File: tb/tb_depacketizer_fsm.sv
// Bench for depacketizer_fsm: directed scenarios plus random frames checked against a frame-level model.
module tb_depacketizer_fsm;
    localparam int BIT_CYC = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_wdata;
    logic       fifo_write_en, rx_busy, frame_error, overrun, parity_error;
    logic [2:0] debug_state;

    depacketizer_fsm #(
        .BAUD_RATE (115200),
        .CLK_FREQ  (50000000),
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .fifo_full    (fifo_full),
        .fifo_wdata   (fifo_wdata),
        .fifo_write_en(fifo_write_en),
        .rx_busy      (rx_busy),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .parity_error (parity_error),
        .debug_state  (debug_state)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Monitor: observed events, written only here
    int         n_wr = 0, n_fe = 0, n_ov = 0, n_pe = 0;
    logic [7:0] got_q[$];
    int         seen_cnt[8] = '{default: 0};
    int         idle_run = 0, last_idle_run = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_write_en) begin
                n_wr <= n_wr + 1;
                got_q.push_back(fifo_wdata);
            end
            if (frame_error)  n_fe <= n_fe + 1;
            if (overrun)      n_ov <= n_ov + 1;
            if (parity_error) n_pe <= n_pe + 1;
            seen_cnt[debug_state] <= seen_cnt[debug_state] + 1;
            if (!rx_busy) begin
                idle_run <= idle_run + 1;
            end else begin
                if (idle_run != 0) last_idle_run <= idle_run;
                idle_run <= 0;
            end
        end
    end

    // Reference model: expected outcome of each frame
    int         e_wr = 0, e_fe = 0, e_ov = 0, e_pe = 0;
    logic [7:0] exp_q[$];
    int         rd_idx = 0;
    int         base[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip,
                               input logic full);
        if (!stop_ok)      e_fe++;
        else if (par_flip) e_pe++;
        else if (full)     e_ov++;
        else begin
            e_wr++;
            exp_q.push_back(d);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        serial_in = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
`ifdef RX_PARITY_EN
        serial_in = (^d) ^ par_flip;
        repeat (BIT_CYC) @(negedge clk);
`endif
        serial_in = stop_bit;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        model_frame(d, stop_bit, par_flip, fifo_full);
        send_frame(d, stop_bit, par_flip);
    endtask

    task automatic check_all(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "/writes"}, n_wr, e_wr);
        chk({tag, "/frame_err"}, n_fe, e_fe);
        chk({tag, "/overrun"}, n_ov, e_ov);
        chk({tag, "/parity_err"}, n_pe, e_pe);
        while (rd_idx < got_q.size() && exp_q.size() > 0) begin
            chk({tag, "/wdata"}, got_q[rd_idx], exp_q.pop_front());
            rd_idx++;
        end
    endtask

    task automatic snap_states();
        for (int i = 0; i < 8; i++) base[i] = seen_cnt[i];
    endtask

    initial begin
        logic [7:0] rd;
        logic       rfull, rstop, rpf;
        int         gap;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst/write_en", fifo_write_en, 0);
        chk("rst/wdata", fifo_wdata, 0);
        chk("rst/busy", rx_busy, 0);
        chk("rst/frame_err", frame_error, 0);
        chk("rst/overrun", overrun, 0);
        chk("rst/parity_err", parity_error, 0);
        chk("rst/state", debug_state, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single frame, state coverage
        snap_states();
        frame(8'hA5, 1'b1, 1'b0);
        check_all("a5");
        chk("a5/wdata_hold", fifo_wdata, 8'hA5);
        for (int s = 0; s < 5; s++)
            chk($sformatf("a5/visit%0d", s), seen_cnt[s] > base[s], 1);

        // Back-to-back frames
        repeat (20) @(negedge clk);
        frame(8'h3C, 1'b1, 1'b0);
        frame(8'h7E, 1'b1, 1'b0);
        check_all("b2b");
        chk("b2b/gap_ok", (last_idle_run >= 1) && (last_idle_run <= BIT_CYC), 1);

        // Start-bit glitch
        repeat (20) @(negedge clk);
        snap_states();
        serial_in = 1'b0;
        repeat (5) @(negedge clk);
        serial_in = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch/visit1", seen_cnt[1] > base[1], 1);
        chk("glitch/state", debug_state, 0);
        check_all("glitch");

        // Framing error followed by break
        frame(8'h55, 1'b0, 1'b0);
        repeat (3 * BIT_CYC) @(negedge clk);
        chk("break/state", debug_state, 5);
        check_all("break");
        serial_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("break/idle", debug_state, 0);

        // Overrun then normal write
        fifo_full = 1'b1;
        frame(8'h81, 1'b1, 1'b0);
        fifo_full = 1'b0;
        repeat (20) @(negedge clk);
        frame(8'h18, 1'b1, 1'b0);
        check_all("overrun");

`ifdef RX_PARITY_EN
        repeat (20) @(negedge clk);
        frame(8'h0F, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        frame(8'h0F, 1'b1, 1'b1);
        check_all("parity");
`endif

        // Random frames
        for (int n = 0; n < 6; n++) begin
            rd    = 8'($urandom);
            rfull = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 4) != 0);
`ifdef RX_PARITY_EN
            rpf   = ($urandom_range(0, 3) == 0);
`else
            rpf   = 1'b0;
`endif
            fifo_full = rfull;
            frame(rd, rstop, rpf);
            serial_in = 1'b1;
            gap = rstop ? int'($urandom_range(0, 300)) : 20;
            repeat (gap) @(negedge clk);
            check_all($sformatf("rand%0d", n));
        end
        fifo_full = 1'b0;

        // Reset in the middle of the data bits
        repeat (20) @(negedge clk);
        serial_in = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        serial_in = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        serial_in = 1'b0;
        repeat (BIT_CYC + BIT_CYC / 3) @(negedge clk);
        rst_n = 1'b0;
        serial_in = 1'b1;
        #1;
        chk("midrst/state", debug_state, 0);
        chk("midrst/busy", rx_busy, 0);
        chk("midrst/write_en", fifo_write_en, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("midrst/idle", debug_state, 0);
        check_all("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
